// File: rtl/lfsr_rng_arbiter.sv
// Shared 17-bit LFSR random-number service, round-robin arbitrated among NREQ requesters.
// Latency: STEPS+1 cycles from the sampling edge to the rnd_valid pulse; one number per STEPS+2 cycles.
// Backpressure: none; requesters hold req until served, seed_load is dropped while busy.
module lfsr_rng_arbiter #(
    parameter int          NREQ         = 4,
    parameter int          STEPS        = 17,
    parameter logic [16:0] SEED_DEFAULT = 17'h1ACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [16:0]      seed,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  rnd_valid,
    output logic [16:0]      rnd_data,
    output logic             busy
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STEP    = 2'd1,
        DELIVER = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [16:0]     lfsr, lfsr_nxt, lfsr_step;
    logic [16:0]     data_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [LW-1:0]   last, last_nxt, win_idx;
    logic            win_found;
    logic [NREQ-1:0] gnt_nxt, valid_nxt;
    int              j;

    // Reciprocal of x^17+x^3+1: shift toward the MSB, feed back s[17]^s[14] into s[1].
    assign lfsr_step = {lfsr[15:0], lfsr[16] ^ lfsr[13]};

    // Round-robin pick: first set request searching upward from the previous winner + 1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last;
        j         = 0;
        for (int i = 1; i <= NREQ; i++) begin
            j = (int'(last) + i) % NREQ;
            if (!win_found && req[j[LW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = j[LW-1:0];
            end
        end
    end

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_nxt = state;
        lfsr_nxt  = lfsr;
        cnt_nxt   = cnt;
        last_nxt  = last;
        gnt_nxt   = gnt;
        valid_nxt = '0;
        data_nxt  = rnd_data;
        case (state)
            IDLE: begin
                gnt_nxt = '0;
                if (seed_load) begin
                    // A zero seed would lock the LFSR, so substitute the default.
                    lfsr_nxt = (seed == 17'd0) ? SEED_DEFAULT : seed;
                end else if (win_found) begin
                    gnt_nxt   = NREQ'(1) << win_idx;
                    last_nxt  = win_idx;
                    cnt_nxt   = CW'(STEPS - 1);
                    state_nxt = STEP;
                end
            end
            STEP: begin
                lfsr_nxt = lfsr_step;
                if (cnt == '0) begin
                    // Capture the value after the final shift so it lines up with the pulse.
                    data_nxt  = lfsr_step;
                    valid_nxt = gnt;
                    state_nxt = DELIVER;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            DELIVER: begin
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: begin
                gnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            lfsr      <= SEED_DEFAULT;
            cnt       <= '0;
            last      <= LW'(NREQ - 1);
            gnt       <= '0;
            rnd_valid <= '0;
            rnd_data  <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            lfsr      <= lfsr_nxt;
            cnt       <= cnt_nxt;
            last      <= last_nxt;
            gnt       <= gnt_nxt;
            rnd_valid <= valid_nxt;
            rnd_data  <= data_nxt;
            busy      <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Bench for lfsr_rng_arbiter: directed and randomized transactions against a behavioural model.
// Latency: checks the STEPS+1 cycle delivery and the STEPS+2 cycle turnaround.
// Backpressure: exercises seeding while busy, same-cycle seed/request and mid-transaction reset.
module tb_lfsr_rng_arbiter;

    localparam int          NREQ  = 4;
    localparam int          STEPS = 17;
    localparam logic [16:0] SDEF  = 17'h1ACE1;

    logic        clk = 1'b0;
    logic        rst;
    logic        seed_load, seed_load2;
    logic [16:0] seed, seed2;
    logic [3:0]  req, req2;
    logic [3:0]  gnt, gnt2, rnd_valid, rnd_valid2;
    logic [16:0] rnd_data, rnd_data2;
    logic        busy, busy2;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [16:0] m_lfsr;
    int          m_last;

    lfsr_rng_arbiter #(.NREQ(NREQ), .STEPS(STEPS), .SEED_DEFAULT(SDEF)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_load),
        .seed      (seed),
        .req       (req),
        .gnt       (gnt),
        .rnd_valid (rnd_valid),
        .rnd_data  (rnd_data),
        .busy      (busy)
    );

    lfsr_rng_arbiter #(.NREQ(NREQ), .STEPS(1), .SEED_DEFAULT(SDEF)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_load2),
        .seed      (seed2),
        .req       (req2),
        .gnt       (gnt2),
        .rnd_valid (rnd_valid2),
        .rnd_data  (rnd_data2),
        .busy      (busy2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance a 17-bit value n times: shift left, new LSB = bit17 xor bit14 (1-based).
    function automatic logic [16:0] adv(input logic [16:0] s, input int n);
        int v;
        v = int'(s);
        for (int i = 0; i < n; i++)
            v = ((v << 1) & 32'h1FFFF) | (((v >> 16) ^ (v >> 13)) & 1);
        return v[16:0];
    endfunction

    // Round-robin: first set bit searching upward from last+1, wrapping.
    function automatic int pick(input int last, input logic [3:0] r);
        for (int i = 1; i <= NREQ; i++)
            if (r[(last + i) % NREQ]) return (last + i) % NREQ;
        return -1;
    endfunction

    // Called at a negedge with the DUT idle; drives req and follows one full transaction.
    task automatic run_txn(input logic [3:0] r, input bit seed_mid, input bit drop_mid);
        int          w;
        int          k;
        logic [16:0] exp;
        req    = r;
        w      = pick(m_last, r);
        m_last = w;
        exp    = adv(m_lfsr, STEPS);
        m_lfsr = exp;
        @(negedge clk);
        k = 1;
        chk("gnt_rise", 32'(gnt), 1 << w);
        while (rnd_valid == 4'd0 && k < STEPS + 10) begin
            chk("gnt_hold", 32'(gnt), 1 << w);
            chk("busy_step", 32'(busy), 1);
            seed_load = seed_mid && (k == 2);
            seed      = 17'($urandom);
            if (drop_mid && k == 3) req = 4'd0;
            @(negedge clk);
            k++;
        end
        seed_load = 1'b0;
        chk("latency", k, STEPS + 1);
        chk("valid", 32'(rnd_valid), 1 << w);
        chk("data", 32'(rnd_data), 32'(exp));
        chk("gnt_dlv", 32'(gnt), 1 << w);
        chk("busy_dlv", 32'(busy), 1);
        @(negedge clk);
        chk("valid_once", 32'(rnd_valid), 0);
        chk("gnt_clr", 32'(gnt), 0);
        chk("busy_idle", 32'(busy), 0);
        chk("data_hold", 32'(rnd_data), 32'(exp));
    endtask

    initial begin
        logic [16:0] s;
        logic [16:0] m2;
        logic [16:0] exp2;
        logic [16:0] c2 [2];
        c2[0] = 17'h00002;
        c2[1] = 17'h00004;

        rst = 1'b0; seed_load = 1'b0; seed = '0; req = '0;
        seed_load2 = 1'b0; seed2 = '0; req2 = '0;
        m_lfsr = SDEF; m_last = NREQ - 1;
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_valid", 32'(rnd_valid), 0);
        chk("rst_data", 32'(rnd_data), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b1;
        @(negedge clk);

        // Seed 1, single request on req[0]
        seed_load = 1'b1; seed = 17'h00001;
        @(negedge clk);
        seed_load = 1'b0; m_lfsr = 17'h00001;
        run_txn(4'b0001, 1'b0, 1'b0);
        chk("t1_const", 32'(rnd_data), 32'h00009);
        req = 4'd0;
        @(negedge clk);

        // All requesting: rotation across every requester twice
        for (int t = 0; t < 8; t++)
            run_txn(4'b1111, 1'b0, 1'b0);
        req = 4'd0;

        // Zero seed falls back to the default; a seed while busy is ignored
        seed_load = 1'b1; seed = 17'd0;
        @(negedge clk);
        seed_load = 1'b0; m_lfsr = SDEF;
        run_txn(4'b0100, 1'b1, 1'b0);
        req = 4'd0;

        // Seed and request in the same idle cycle: seed wins, grant follows
        s = 17'($urandom_range(1, 17'h1FFFF));
        seed_load = 1'b1; seed = s; req = 4'b0010;
        @(negedge clk);
        chk("seed_nogrant", 32'(gnt), 0);
        chk("seed_nobusy", 32'(busy), 0);
        seed_load = 1'b0; m_lfsr = s;
        run_txn(4'b0010, 1'b0, 1'b0);
        req = 4'd0;

        // Randomized mix of seeds, request patterns, busy seeds and req drops
        for (int t = 0; t < 12; t++) begin
            if ($urandom_range(0, 2) == 0) begin
                s = ($urandom_range(0, 3) == 0) ? 17'd0 : 17'($urandom);
                req = 4'd0; seed_load = 1'b1; seed = s;
                @(negedge clk);
                seed_load = 1'b0;
                m_lfsr = (s == 17'd0) ? SDEF : s;
            end
            run_txn(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        req = 4'd0;

        // Reset in the middle of STEP aborts with no pulse
        req = 4'b1111;
        @(negedge clk);
        @(negedge clk);
        req = 4'd0; rst = 1'b0;
        #1;
        chk("arst_gnt", 32'(gnt), 0);
        chk("arst_valid", 32'(rnd_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        #1 rst = 1'b1;
        m_lfsr = SDEF; m_last = NREQ - 1;
        @(negedge clk);
        chk("post_rst_valid", 32'(rnd_valid), 0);
        run_txn(4'b1111, 1'b0, 1'b0);
        chk("post_rst_data", 32'(rnd_data), 32'(adv(SDEF, STEPS)));
        req = 4'd0;

        // STEPS=1 instance: seed 1, two back-to-back requests on req[2]
        seed_load2 = 1'b1; seed2 = 17'h00001;
        @(negedge clk);
        seed_load2 = 1'b0; req2 = 4'b0100; m2 = 17'h00001;
        for (int t = 0; t < 2; t++) begin
            exp2 = adv(m2, 1);
            m2   = exp2;
            @(negedge clk);
            chk("s1_gnt", 32'(gnt2), 32'h4);
            chk("s1_novalid", 32'(rnd_valid2), 0);
            chk("s1_busy", 32'(busy2), 1);
            @(negedge clk);
            chk("s1_valid", 32'(rnd_valid2), 32'h4);
            chk("s1_data", 32'(rnd_data2), 32'(exp2));
            chk("s1_const", 32'(rnd_data2), 32'(c2[t]));
            @(negedge clk);
            chk("s1_idle", 32'(gnt2), 0);
        end
        req2 = 4'd0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_rng_arbiter.md
Name: lfsr_rng_arbiter

Overview:
Shared random-number service. It owns one 17-bit maximal-length LFSR and arbitrates round-robin among NREQ requesters. For each grant it advances the LFSR STEPS times so that successive outputs are decorrelated, then delivers the value to the granted requester with a one-cycle valid pulse. It also provides software seeding with zero-seed protection, and sits between the LFSR datapath and consumer blocks such as test-pattern generators or game logic.

Parameters:
NREQ, 4, number of requesters (2..8)
STEPS, 17, LFSR shifts per delivered number (must be >= 1)
SEED_DEFAULT, 17'h1ACE1, reset and zero-seed substitute value (must be nonzero)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
seed_load  input  1  load seed into LFSR (honoured in IDLE only)
seed  input  17  seed value
req  input  NREQ  per-requester request, level
gnt  output  NREQ  one-hot grant, held for the whole transaction
rnd_valid  output  NREQ  one-cycle pulse to the granted requester
rnd_data  output  17  delivered random number, held until the next delivery
busy  output  1  high in STEP and DELIVER

Behaviour:
- Reset: we use clock clk and reset rst (asynchronous, active-low).
  - While rst=0, all of the following take effect immediately: state=IDLE, LFSR=SEED_DEFAULT, gnt=0, rnd_valid=0, rnd_data=0, busy=0, step counter=0.
  - The round-robin pointer resets to last=NREQ-1, so req[0] has first priority.
  - A reset mid-transaction aborts it with no valid pulse.
- LFSR step (s[17:1]): s[17:2] <= s[16:1]; s[1] <= s[17] ^ s[14]. This is the reciprocal of x^17+x^3+1 and has period 2^17-1.
- Seeding:
  - In IDLE, seed_load=1 loads seed, or SEED_DEFAULT if seed==0. The state stays IDLE.
  - seed_load has priority over req in the same cycle; no grant is issued that cycle.
  - seed_load in STEP or DELIVER is ignored and not queued.
- FSM:
  - IDLE: if seed_load=0 and req!=0, select the first set req bit searching upward from last+1 with wrap-around. Register gnt (one-hot), set last=winner, cnt=STEPS-1, go to STEP.
  - STEP: LFSR steps every cycle. When cnt==0, go to DELIVER; else cnt--. Exactly STEPS shifts occur.
  - DELIVER: rnd_data<=LFSR value (a registered copy, visible alongside the pulse). rnd_valid[winner]=1 for this one cycle. gnt stays asserted. No shift occurs. Next state is IDLE, where gnt is cleared.
- Timing: req sampled high in IDLE at edge t gives gnt high from t+1 and rnd_valid high during cycle t+STEPS+1. Latency is STEPS+1 cycles; throughput is one number per STEPS+2 cycles.
- Requester handshake:
  - A requester deasserts req on the edge after its rnd_valid.
  - If req is still high in IDLE it re-enters arbitration, but the rotation gives other pending requesters priority first.
  - A req drop mid-transaction does not abort; the valid pulse still occurs.
- Invariants:
  - gnt is zero or one-hot.
  - rnd_valid is always a subset of gnt.
  - rnd_valid is high in at most one cycle per transaction.
  - The LFSR never holds 0.
  - busy = (state != IDLE).
- All outputs are registered.

Test Plan:
1. Reset with STEPS=17, seed_load seed=17'h00001, then req=4'b0001 → gnt=0001 one cycle after sampling; rnd_valid[0] pulses 18 cycles after sampling with rnd_data=17'h00009; busy high for 18 cycles.
2. STEPS=1 build, seed 17'h00001, two back-to-back single requests on req[2] → rnd_data 17'h00002 then 17'h00004; each valid arrives 2 cycles after its sampling edge.
3. req=4'b1111 held continuously → grant order 0,1,2,3,0,...; each gnt lasts STEPS+1 cycles; never two bits set at once.
4. seed_load with seed=0 in IDLE → LFSR=17'h1ACE1. seed_load while busy → ignored; the delivered value matches the un-reseeded reference model.
5. seed_load and req[1] high in the same IDLE cycle → seed loaded and no grant that cycle; grant to 1 on the following cycle.
6. rst pulsed low mid-STEP → gnt, rnd_valid and busy go 0 immediately with no valid pulse. After release, the first delivery equals SEED_DEFAULT advanced STEPS times, and req[0] wins a 4'b1111 contention.
